// File: rtl/pokeball_throw_ctrl_if.sv
// Handshake bundle between game logic (master) and the pokeball throw sequencer (slave),
// carrying both the throw request and the sprite outputs towards the renderer.
interface pokeball_throw_ctrl_if;
  logic       frame_tick;
  logic       throw;
  logic [9:0] start_x;
  logic [8:0] start_y;
  logic [9:0] target_x;
  logic [8:0] target_y;
  logic [7:0] catch_rate;
  logic [9:0] x0;
  logic [8:0] y0;
  logic       enable;
  logic       busy;
  logic       done;
  logic       caught;

  modport master (
    output frame_tick, throw, start_x, start_y, target_x, target_y, catch_rate,
    input  x0, y0, enable, busy, done, caught
  );

  modport slave (
    input  frame_tick, throw, start_x, start_y, target_x, target_y, catch_rate,
    output x0, y0, enable, busy, done, caught
  );
endinterface

// File: rtl/pokeball_throw_ctrl.sv
// Frame-by-frame pokeball throw animation: flight, optional wobble, capture roll, result hold.
// Define POKEBALL_WOBBLE_EN to build the wobble phase between arrival and result.
module pokeball_throw_ctrl #(
  parameter int unsigned STEP_X        = 4,
  parameter int unsigned STEP_Y        = 4,
  parameter int unsigned WOBBLE_FRAMES = 4,
  parameter int unsigned NUM_WOBBLES   = 3,
  parameter int unsigned HOLD_FRAMES   = 30
) (
  input  logic                clk,
  input  logic                rst,
  pokeball_throw_ctrl_if.slave bus
);

  localparam int unsigned Max1   = (HOLD_FRAMES > WOBBLE_FRAMES) ? HOLD_FRAMES : WOBBLE_FRAMES;
  localparam int unsigned CntMax = (Max1 > 2 * NUM_WOBBLES) ? Max1 : 2 * NUM_WOBBLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_FRAMES - 1);
  localparam logic [9:0]      StepX    = 10'(STEP_X);
  localparam logic [9:0]      StepY    = 10'(STEP_Y);

`ifdef POKEBALL_WOBBLE_EN
  localparam logic [CntW-1:0] WobLast  = CntW'(WOBBLE_FRAMES - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(2 * NUM_WOBBLES - 1);

  typedef enum logic [2:0] {StIdle, StFlight, StWobble, StResult, StHold} state_e;
`else
  typedef enum logic [2:0] {StIdle, StFlight, StResult, StHold} state_e;
`endif

  state_e          state_q, state_d;
  logic [9:0]      x0_q, x0_d;
  logic [8:0]      y0_q, y0_d;
  logic [9:0]      tx_q, tx_d;
  logic [8:0]      ty_q, ty_d;
  logic [7:0]      rate_q, rate_d;
  logic            enable_q, enable_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            caught_q, caught_d;
  logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]      lfsr_q, lfsr_d;
`ifdef POKEBALL_WOBBLE_EN
  logic [CntW-1:0] half_cnt_q, half_cnt_d;
`endif

  // Move one step toward tgt, snapping onto it when within reach; 11-bit math avoids wrap.
  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic [9:0] tgt,
                                           input logic [9:0] step);
    logic [10:0] diff;
    if (tgt >= pos) begin
      diff = {1'b0, tgt} - {1'b0, pos};
      step_axis = (diff <= {1'b0, step}) ? tgt : 10'({1'b0, pos} + {1'b0, step});
    end else begin
      diff = {1'b0, pos} - {1'b0, tgt};
      step_axis = (diff <= {1'b0, step}) ? tgt : 10'({1'b0, pos} - {1'b0, step});
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    tx_d        = tx_q;
    ty_d        = ty_q;
    rate_d      = rate_q;
    enable_d    = enable_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    caught_d    = caught_q;
    frame_cnt_d = frame_cnt_q;
    // x^8+x^6+x^5+x^4+1, free-running so the capture roll depends on throw timing
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`ifdef POKEBALL_WOBBLE_EN
    half_cnt_d  = half_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.throw) begin
          tx_d     = bus.target_x;
          ty_d     = bus.target_y;
          rate_d   = bus.catch_rate;
          x0_d     = bus.start_x;
          y0_d     = bus.start_y;
          enable_d = 1'b1;
          busy_d   = 1'b1;
          caught_d = 1'b0;
          state_d  = StFlight;
        end
      end

      StFlight: begin
        if (bus.frame_tick) begin
          x0_d = step_axis(x0_q, tx_q, StepX);
          y0_d = 9'(step_axis({1'b0, y0_q}, {1'b0, ty_q}, StepY));
          if (x0_d == tx_q && y0_d == ty_q) begin
            frame_cnt_d = '0;
`ifdef POKEBALL_WOBBLE_EN
            half_cnt_d  = '0;
            state_d     = StWobble;
`else
            done_d      = 1'b1;
            state_d     = StResult;
`endif
          end
        end
      end

`ifdef POKEBALL_WOBBLE_EN
      StWobble: begin
        if (bus.frame_tick) begin
          // Even half-swings lean one pixel right, odd ones sit on the target.
          x0_d = half_cnt_q[0] ? tx_q : 10'(tx_q + 10'd1);
          if (frame_cnt_q == WobLast) begin
            frame_cnt_d = '0;
            if (half_cnt_q == HalfLast) begin
              x0_d    = tx_q;
              done_d  = 1'b1;
              state_d = StResult;
            end else begin
              half_cnt_d = half_cnt_q + 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
`endif

      StResult: begin
        caught_d    = (lfsr_q <= rate_q);
        enable_d    = caught_d;
        frame_cnt_d = '0;
        state_d     = StHold;
      end

      StHold: begin
        if (bus.frame_tick) begin
          if (frame_cnt_q == HoldLast) begin
            frame_cnt_d = '0;
            busy_d      = 1'b0;
            enable_d    = 1'b0;
            state_d     = StIdle;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      x0_q        <= '0;
      y0_q        <= '0;
      tx_q        <= '0;
      ty_q        <= '0;
      rate_q      <= '0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      caught_q    <= 1'b0;
      frame_cnt_q <= '0;
      lfsr_q      <= 8'hA5;
`ifdef POKEBALL_WOBBLE_EN
      half_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      rate_q      <= rate_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      caught_q    <= caught_d;
      frame_cnt_q <= frame_cnt_d;
      lfsr_q      <= lfsr_d;
`ifdef POKEBALL_WOBBLE_EN
      half_cnt_q  <= half_cnt_d;
`endif
    end
  end

  assign bus.x0     = x0_q;
  assign bus.y0     = y0_q;
  assign bus.enable = enable_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.caught = caught_q;

endmodule
